// File: rtl/evt_pulse_sched_if.sv
// Event scheduler bundle: event lines and resource status in, grant and status flags out.
// The master side drives the event sources and resource status; the slave side is the scheduler.
interface evt_pulse_sched_if #(
    parameter int N_SRC = 4
);
    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] sig_in;
    logic             en;
    logic             res_busy;
    logic             ovf_clr;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] ovf;
    logic             tmo;

    modport master (
        output sig_in,
        output en,
        output res_busy,
        output ovf_clr,
        input  grant_vld,
        input  grant_id,
        input  pend,
        input  ovf,
        input  tmo
    );

    modport slave (
        input  sig_in,
        input  en,
        input  res_busy,
        input  ovf_clr,
        output grant_vld,
        output grant_id,
        output pend,
        output ovf,
        output tmo
    );
endinterface

// File: rtl/evt_pulse_sched.sv
// Round-robin event pulse scheduler.
// Captures rising edges on N_SRC event lines as pending requests, grants one source at a
// time to a shared resource, then waits for the resource to go busy and to finish.
//
//   state     | meaning
//   ----------+----------------------------------------------------------------
//   IDLE      | waiting for EN, a pending source and a free resource
//   GRANT     | one-cycle grant pulse; pending bit of the winner is cleared
//   WAIT_BUSY | waiting for the resource to acknowledge by going busy (timed)
//   WAIT_DONE | resource busy; waiting for it to release
module evt_pulse_sched #(
    parameter int N_SRC   = 4,
    parameter int TMO_CYC = 16
) (
    input  logic             CLK,
    input  logic             RST,
    evt_pulse_sched_if.slave bus
);

    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [N_SRC-1:0] s1;
    logic [N_SRC-1:0] s2;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] ovf_q;
    logic [N_SRC-1:0] ovf_set;
    logic             tmo_q;

    logic [ID_W-1:0]  grant_id_q;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic             win_vld;

    logic [7:0]       tmr;
    logic             tmr_done;

    logic             grant_pulse;
    logic             take_grant;
    logic             tmr_load;
    logic             tmo_set;

    // Index of the k-th source counting upward from base, wrapping at N_SRC.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= N_SRC) begin
            j = j - N_SRC;
        end
        return ID_W'(j);
    endfunction

    // Two-stage edge detector per source; a line held high through reset release
    // produces one event because s2 leaves reset low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
        end
    end

    assign rise = s1 & ~s2;

    // Clear mask for the source being granted this cycle.
    always_comb begin
        pend_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pend_clr[i] = grant_pulse && (grant_id_q == ID_W'(i));
        end
    end

    // A repeat event on an already pending source is lost, unless the pending bit is being
    // consumed by the grant in the same cycle, in which case the new event simply re-arms it.
    assign ovf_set = rise & pend_q & ~pend_clr;

    // Pending flags: set by an event, cleared only by a grant; set wins.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend_q <= '0;
        end else begin
            pend_q <= rise | (pend_q & ~pend_clr);
        end
    end

    // Sticky overflow flags; a new overflow wins over a simultaneous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~{N_SRC{bus.ovf_clr}});
        end
    end

    // Sticky timeout flag; a new timeout wins over a simultaneous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_set | (tmo_q & ~bus.ovf_clr);
        end
    end

    // Round-robin pick: scanning downward means the last hit is the pending source
    // closest to rr_ptr going upward with wrap.
    always_comb begin
        winner  = '0;
        win_vld = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (pend_q[rr_idx(rr_ptr, k)]) begin
                winner  = rr_idx(rr_ptr, k);
                win_vld = 1'b1;
            end
        end
    end

    // Winner is latched when leaving IDLE and held until the next grant.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            grant_id_q <= '0;
        end else if (take_grant) begin
            grant_id_q <= winner;
        end
    end

    // Round-robin pointer moves just past the source that was granted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rr_ptr <= '0;
        end else if (grant_pulse) begin
            if (grant_id_q == ID_W'(N_SRC - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id_q + ID_W'(1);
            end
        end
    end

    // Busy-acknowledge timer: loaded during GRANT, counts down while waiting for busy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmr <= '0;
        end else if (tmr_load) begin
            tmr <= 8'(TMO_CYC);
        end else if (state == WAIT_BUSY && tmr != 8'd0) begin
            tmr <= tmr - 8'd1;
        end
    end

    // Terminal count: this is the last allowed WAIT_BUSY cycle.
    assign tmr_done = (tmr == 8'd1);

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; EN is only consulted in IDLE so a started sequence completes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.en && win_vld && !bus.res_busy) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.res_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmr_done) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.res_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM outputs and datapath controls.
    always_comb begin
        grant_pulse = 1'b0;
        take_grant  = 1'b0;
        tmr_load    = 1'b0;
        tmo_set     = 1'b0;
        case (state)
            IDLE: begin
                take_grant = (state_nxt == GRANT);
            end
            GRANT: begin
                grant_pulse = 1'b1;
                tmr_load    = 1'b1;
            end
            WAIT_BUSY: begin
                tmo_set = !bus.res_busy && tmr_done;
            end
            default: begin
                grant_pulse = 1'b0;
            end
        endcase
    end

    assign bus.grant_vld = grant_pulse;
    assign bus.grant_id  = grant_id_q;
    assign bus.pend      = pend_q;
    assign bus.ovf       = ovf_q;
    assign bus.tmo       = tmo_q;

endmodule

// File: tb/tb_evt_pulse_sched.sv
// Directed bench for evt_pulse_sched: a vector table for the basic and round-robin
// sequences, then hand-written sequences for overflow, timeout, grant-cycle events
// and reset behaviour.
module tb_evt_pulse_sched;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    evt_pulse_sched_if #(.N_SRC(N)) bus ();

    evt_pulse_sched #(
        .N_SRC  (N),
        .TMO_CYC(TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] sig;
        logic       en;
        logic       busy;
        logic       clr;
        logic       gv;
        logic [1:0] id;
        logic [3:0] pend;
        logic [3:0] ovf;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] s, input logic e,
                                input logic b, input logic c, input logic gv,
                                input logic [1:0] id, input logic [3:0] p,
                                input logic [3:0] o, input logic t);
        vec_t v;
        v.rst_n = r; v.sig = s; v.en = e; v.busy = b; v.clr = c;
        v.gv = gv; v.id = id; v.pend = p; v.ovf = o; v.tmo = t;
        vecs.push_back(v);
    endfunction

    // One clock: drive at the falling edge (releasing reset), sample 1 ns after the rising edge.
    task automatic step(input logic [3:0] s, input logic e, input logic b, input logic c);
        @(negedge CLK);
        RST          = 1'b1;
        bus.sig_in   = s;
        bus.en       = e;
        bus.res_busy = b;
        bus.ovf_clr  = c;
        @(posedge CLK);
        #1;
    endtask

    // Hold reset over one rising edge; the next step() releases it.
    task automatic reset_dut(input logic [3:0] s);
        @(negedge CLK);
        RST          = 1'b0;
        bus.sig_in   = s;
        bus.en       = 1'b1;
        bus.res_busy = 1'b0;
        bus.ovf_clr  = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int grants;

        bus.sig_in   = '0;
        bus.en       = 1'b0;
        bus.res_busy = 1'b0;
        bus.ovf_clr  = 1'b0;

        //  rst sig      en bsy clr | gv id pend     ovf      tmo
        // single source: latency, busy for 3 cycles, back to IDLE
        add(0, 4'b0000, 1, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b0001, 1, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b0001, 1, 0, 0,   0, 0, 4'b0001, 4'b0000, 0);
        add(1, 4'b0001, 1, 0, 0,   1, 0, 4'b0001, 4'b0000, 0);
        add(1, 4'b0001, 1, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b0001, 1, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b0001, 1, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b0001, 1, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b0001, 1, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b0001, 1, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        // all four fire together: round-robin 0,1,2,3 then source 1 re-fires
        add(0, 4'b0000, 1, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b0000, 1, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 0, 4'b1111, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   1, 0, 4'b1111, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 0, 4'b1110, 4'b0000, 0);
        add(1, 4'b1111, 1, 1, 0,   0, 0, 4'b1110, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 0, 4'b1110, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   1, 1, 4'b1110, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 1, 4'b1100, 4'b0000, 0);
        add(1, 4'b1111, 1, 1, 0,   0, 1, 4'b1100, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 1, 4'b1100, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   1, 2, 4'b1100, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 2, 4'b1000, 4'b0000, 0);
        add(1, 4'b1111, 1, 1, 0,   0, 2, 4'b1000, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 2, 4'b1000, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   1, 3, 4'b1000, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 3, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 1, 1, 0,   0, 3, 4'b0000, 4'b0000, 0);
        add(1, 4'b1101, 1, 0, 0,   0, 3, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 3, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 3, 4'b0010, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   1, 1, 4'b0010, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 1, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 1, 1, 0,   0, 1, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 0,   0, 1, 4'b0000, 4'b0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            RST          = vecs[i].rst_n;
            bus.sig_in   = vecs[i].sig;
            bus.en       = vecs[i].en;
            bus.res_busy = vecs[i].busy;
            bus.ovf_clr  = vecs[i].clr;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d.grant_vld", i), bus.grant_vld, vecs[i].gv);
            chk($sformatf("v%0d.grant_id", i),  bus.grant_id,  vecs[i].id);
            chk($sformatf("v%0d.pend", i),      bus.pend,      vecs[i].pend);
            chk($sformatf("v%0d.ovf", i),       bus.ovf,       vecs[i].ovf);
            chk($sformatf("v%0d.tmo", i),       bus.tmo,       vecs[i].tmo);
        end

        // Overflow while EN=0, single grant once enabled, then clear.
        reset_dut(4'b0000);
        step(4'b0100, 0, 0, 0);
        chk("ovf.pend_lat", bus.pend, 4'b0000);
        step(4'b0100, 0, 0, 0);
        chk("ovf.pend_set", bus.pend, 4'b0100);
        step(4'b0000, 0, 0, 0);
        step(4'b0000, 0, 0, 0);
        step(4'b0100, 0, 0, 0);
        chk("ovf.not_yet", bus.ovf, 4'b0000);
        step(4'b0100, 0, 0, 0);
        chk("ovf.set", bus.ovf, 4'b0100);
        chk("ovf.pend_kept", bus.pend, 4'b0100);
        chk("ovf.no_grant_en0", bus.grant_vld, 1'b0);
        step(4'b0100, 1, 0, 0);
        chk("ovf.grant_vld", bus.grant_vld, 1'b1);
        chk("ovf.grant_id", bus.grant_id, 2'd2);
        step(4'b0100, 1, 0, 0);
        chk("ovf.pend_clr", bus.pend, 4'b0000);
        step(4'b0100, 1, 1, 0);
        step(4'b0100, 1, 0, 0);
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            step(4'b0100, 1, 0, 0);
            if (bus.grant_vld) grants++;
        end
        chk("ovf.single_grant", grants, 0);
        chk("ovf.sticky", bus.ovf, 4'b0100);
        step(4'b0100, 1, 0, 1);
        chk("ovf.cleared", bus.ovf, 4'b0000);

        // Timeout: busy never rises; Tmo on the 16th WAIT_BUSY cycle, then next source.
        reset_dut(4'b0000);
        step(4'b0011, 1, 0, 0);
        step(4'b0011, 1, 0, 0);
        chk("tmo.pend", bus.pend, 4'b0011);
        step(4'b0011, 1, 0, 0);
        chk("tmo.grant0_vld", bus.grant_vld, 1'b1);
        chk("tmo.grant0_id", bus.grant_id, 2'd0);
        step(4'b0011, 1, 0, 0);
        for (int i = 0; i < TMO - 1; i++) begin
            step(4'b0011, 1, 0, 0);
        end
        chk("tmo.not_early", bus.tmo, 1'b0);
        chk("tmo.no_grant_waiting", bus.grant_vld, 1'b0);
        step(4'b0011, 1, 0, 1);
        chk("tmo.set_wins_clr", bus.tmo, 1'b1);
        step(4'b0011, 1, 0, 1);
        chk("tmo.next_grant_vld", bus.grant_vld, 1'b1);
        chk("tmo.next_grant_id", bus.grant_id, 2'd1);
        chk("tmo.cleared", bus.tmo, 1'b0);

        // Event on the granted source during GRANT, then reset in WAIT_DONE.
        reset_dut(4'b0000);
        step(4'b0001, 1, 0, 0);
        step(4'b0000, 1, 0, 0);
        chk("gc.pend", bus.pend, 4'b0001);
        step(4'b0001, 1, 0, 0);
        chk("gc.grant_vld", bus.grant_vld, 1'b1);
        chk("gc.grant_id", bus.grant_id, 2'd0);
        step(4'b0001, 1, 0, 0);
        chk("gc.pend_rearmed", bus.pend, 4'b0001);
        chk("gc.no_ovf", bus.ovf, 4'b0000);
        step(4'b0001, 1, 1, 0);
        step(4'b0001, 1, 1, 0);
        chk("rst.pend_before", bus.pend, 4'b0001);
        @(negedge CLK);
        bus.sig_in = 4'b0000;
        RST        = 1'b0;
        #2;
        chk("rst.grant_vld", bus.grant_vld, 1'b0);
        chk("rst.grant_id", bus.grant_id, 2'd0);
        chk("rst.pend", bus.pend, 4'b0000);
        chk("rst.ovf", bus.ovf, 4'b0000);
        chk("rst.tmo", bus.tmo, 1'b0);
        @(posedge CLK);
        #1;
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1, 0, 0);
            if (bus.grant_vld) grants++;
        end
        chk("rst.no_grant_after", grants, 0);
        chk("rst.pend_after", bus.pend, 4'b0000);

        // A line already high at reset release counts as one event.
        reset_dut(4'b0010);
        step(4'b0010, 1, 0, 0);
        chk("rel.pend_lat", bus.pend, 4'b0000);
        step(4'b0010, 1, 0, 0);
        chk("rel.pend", bus.pend, 4'b0010);
        step(4'b0010, 1, 0, 0);
        chk("rel.grant_vld", bus.grant_vld, 1'b1);
        chk("rel.grant_id", bus.grant_id, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
